// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: bus widths, opcodes, result
// classes and divider state encodings.
package ex_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;

    localparam logic RstEnable   = 1'b1;
    localparam logic StallEnable = 1'b1;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_ZERO = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

    function automatic logic [RegBus-1:0] abs32(input logic [RegBus-1:0] v);
        return v[RegBus-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider: 32 shift-subtract steps on a 65-bit
// register, with magnitude capture and sign fix-up for signed division.
module ex_div
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [RegBus-1:0] op1_i,
    input  logic [RegBus-1:0] op2_i,
    input  logic              cancel_i,
    output logic [63:0]       result_o,
    output logic              ready_o,
    output logic              busy_o
);

    div_state_e        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [64:0]       dividend_q, dividend_d;
    logic [RegBus-1:0] divisor_q, divisor_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;

    logic [32:0]       diff;
    logic [RegBus-1:0] opa, opb, quot, rem;

    assign opa  = signed_i ? abs32(op1_i) : op1_i;
    assign opb  = signed_i ? abs32(op2_i) : op2_i;
    assign diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    cnt_d      = 6'd0;
                    divisor_d  = opb;
                    neg_rem_d  = signed_i && op1_i[31];
                    neg_quot_d = signed_i && (op1_i[31] ^ op2_i[31]);
                    if (op2_i == '0) begin
                        // Remainder slot holds |dividend| so the sign fix-up restores it.
                        state_d    = DIV_ZERO;
                        neg_quot_d = 1'b0;
                        dividend_d = {opa, 1'b0, 32'hFFFF_FFFF};
                    end else begin
                        state_d    = DIV_BUSY;
                        dividend_d = {32'd0, opa, 1'b0};
                    end
                end
            end
            DIV_BUSY: begin
                if (diff[32]) begin
                    dividend_d = {dividend_q[63:0], 1'b0};
                end else begin
                    dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
                end
                if (cnt_q == 6'd31) begin
                    state_d = DIV_DONE;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DIV_ZERO: state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (cancel_i) begin
            state_d = DIV_IDLE;
            cnt_d   = 6'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= 6'd0;
            dividend_q <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    assign quot     = dividend_q[31:0];
    assign rem      = dividend_q[64:33];
    assign result_o = {neg_rem_q ? (~rem + 32'd1) : rem,
                       neg_quot_q ? (~quot + 32'd1) : quot};
    assign ready_o  = (state_q == DIV_DONE) && !cancel_i;
    assign busy_o   = !cancel_i && ((state_q == DIV_BUSY) || (state_q == DIV_ZERO) ||
                                    ((state_q == DIV_IDLE) && start_i));

endmodule

// File: rtl/ex.sv
// MIPS execute stage: combinational logic/shift ALU plus HI/LO divider with
// pipeline stall. The divider is only built when EX_DIV_EN is defined.
module ex
    import ex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [AluSelBus-1:0]  alusel_i,
    input  logic [RegBus-1:0]     reg1_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [RegBus-1:0]     wdata_o,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     hi_o,
    output logic [RegBus-1:0]     lo_o,
    output logic                  whilo_o,
    output logic                  stallreq_o
);

    logic [RegBus-1:0] logic_res;
    logic [RegBus-1:0] shift_res;
    logic              is_div;

    assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
            EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        wdata_o = '0;
        wd_o    = '0;
        wreg_o  = 1'b0;
        if (rst != RstEnable) begin
            wd_o   = wd_i;
            wreg_o = wreg_i && !is_div;
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                default:       wdata_o = '0;
            endcase
        end
    end

`ifdef EX_DIV_EN
    logic [63:0] div_result;
    logic        div_ready;
    logic        div_busy;

    ex_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start_i  (is_div && !flush_i),
        .signed_i (aluop_i == EXE_DIV_OP),
        .op1_i    (reg1_i),
        .op2_i    (reg2_i),
        .cancel_i (flush_i),
        .result_o (div_result),
        .ready_o  (div_ready),
        .busy_o   (div_busy)
    );

    // An issue cycle presented during reset must not raise the stall.
    assign stallreq_o = (rst != RstEnable) && div_busy ? StallEnable : !StallEnable;
    assign whilo_o    = div_ready;
    assign hi_o       = div_ready ? div_result[63:32] : '0;
    assign lo_o       = div_ready ? div_result[31:0]  : '0;
`else
    logic unused_div_inputs;
    assign unused_div_inputs = ^{clk, flush_i};
    assign stallreq_o = !StallEnable;
    assign whilo_o    = 1'b0;
    assign hi_o       = '0;
    assign lo_o       = '0;
`endif

endmodule
